mem_port_sched: RTL



---
 rtl/mem_port_sched_pkg.sv | 19 +
 rtl/mem_port_sched_rr_arbiter.sv | 28 ++
 rtl/mem_port_sched.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_sched_pkg.sv
// Shared types for the OTTER data-memory port scheduler: CDB tag, scheduler
// state encoding and memory-type field constants.
package mem_port_sched_pkg;

    localparam int TAG_W = 5;
    typedef logic [TAG_W-1:0] RS_tag_type;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        BCAST  = 2'd2
    } sched_state_e;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
    localparam int MEM_TYPE_UNSIGNED_BIT = 2;

endpackage

// File: rtl/mem_port_sched_rr_arbiter.sv
// Round-robin pick among N requesters: the first asserted req at or above ptr
// (wrapping) wins; returns one-hot grant, winner index and a valid flag.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        // Scan from the farthest offset down so the nearest requester overwrites last.
        for (int off = N - 1; off >= 0; off--) begin
            if (req[(int'(ptr) + off) % N]) begin
                gnt = '0;
                gnt[(int'(ptr) + off) % N] = 1'b1;
                idx   = $clog2(N)'((int'(ptr) + off) % N);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_sched.sv
// Data-memory port scheduler: shares MEM_ADDR2 between N_LD load stations and
// the store drain, and broadcasts load results on the CDB. Optional watchdog: MEM_TIMEOUT_EN.
module mem_port_sched
    import mem_port_sched_pkg::*;
#(
    parameter int N_LD    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [N_LD-1:0]            ld_req,
    input  logic [N_LD-1:0][31:0]      ld_addr,
    input  logic [N_LD-1:0][2:0]       ld_type,
    input  RS_tag_type [N_LD-1:0]      ld_tag,
    output logic [N_LD-1:0]            ld_grant,
    input  logic                       st_req,
    input  logic [31:0]                st_addr,
    input  logic [31:0]                st_data,
    input  logic [2:0]                 st_type,
    output logic                       st_ack,
    input  logic                       flush,
    output logic [31:0]                MEM_ADDR2,
    output logic [31:0]                MEM_DIN2,
    output logic                       MEM_READ,
    output logic                       MEM_WRITE,
    output logic [1:0]                 MEM_SIZE,
    output logic                       MEM_SIGN,
    input  logic                       mem_resp_valid,
    input  logic [31:0]                mem_data_in,
    output logic                       CDB_req,
    input  logic                       CDB_grant,
    output logic [31:0]                CDB_val,
    output RS_tag_type                 CDB_tag,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int PW = $clog2(N_LD);

    sched_state_e   state_q, state_d;
    logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
    logic           is_store_q, is_store_d;
    logic           discard_q, discard_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    data_q, data_d;
    logic [2:0]     type_q, type_d;
    RS_tag_type     tag_q, tag_d;
    logic [31:0]    cdb_val_q, cdb_val_d;

    logic [N_LD-1:0] arb_gnt;
    logic [PW-1:0]   arb_idx;
    logic            arb_valid;

`ifdef MEM_TIMEOUT_EN
    localparam logic [3:0] TO_LIMIT = 4'(TIMEOUT);
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^4'(TIMEOUT);
`endif

    rr_arbiter #(.N(N_LD)) u_arb (
        .req   (ld_req),
        .ptr   (rr_ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        is_store_d = is_store_q;
        discard_d  = discard_q;
        addr_d     = addr_q;
        data_d     = data_q;
        type_d     = type_q;
        tag_d      = tag_q;
        cdb_val_d  = cdb_val_q;
        ld_grant   = '0;
        st_ack     = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (st_req) begin
                    is_store_d = 1'b1;
                    addr_d     = st_addr;
                    data_d     = st_data;
                    type_d     = st_type;
                    state_d    = ACCESS;
`ifdef MEM_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end else if (arb_valid && !flush) begin
                    ld_grant   = arb_gnt;
                    is_store_d = 1'b0;
                    addr_d     = ld_addr[arb_idx];
                    data_d     = '0;
                    type_d     = ld_type[arb_idx];
                    tag_d      = ld_tag[arb_idx];
                    rr_ptr_d   = (arb_idx == PW'(N_LD - 1)) ? '0 : arb_idx + 1'b1;
                    state_d    = ACCESS;
`ifdef MEM_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            ACCESS: begin
                if (mem_resp_valid) begin
                    if (is_store_q) begin
                        st_ack  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cdb_val_d = mem_data_in;
                        // A flush arriving with the response still squashes it.
                        if (discard_q || flush) begin
                            discard_d = 1'b0;
                            state_d   = IDLE;
                        end else begin
                            state_d = BCAST;
                        end
                    end
                end else begin
                    if (!is_store_q && flush) discard_d = 1'b1;
`ifdef MEM_TIMEOUT_EN
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d == TO_LIMIT) begin
                        err_d     = 1'b1;
                        discard_d = 1'b0;
                        state_d   = IDLE;
                    end
`endif
                end
            end
            BCAST: begin
                if (CDB_grant || flush) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            is_store_q <= 1'b0;
            discard_q  <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            type_q     <= '0;
            tag_q      <= '0;
            cdb_val_q  <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            is_store_q <= is_store_d;
            discard_q  <= discard_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            type_q     <= type_d;
            tag_q      <= tag_d;
            cdb_val_q  <= cdb_val_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign MEM_READ  = (state_q == ACCESS) && !is_store_q;
    assign MEM_WRITE = (state_q == ACCESS) && is_store_q;
    assign MEM_ADDR2 = addr_q;
    assign MEM_DIN2  = data_q;
    assign MEM_SIZE  = type_q[1:0];
    assign MEM_SIGN  = type_q[MEM_TYPE_UNSIGNED_BIT];
    assign CDB_req   = (state_q == BCAST);
    assign CDB_val   = cdb_val_q;
    assign CDB_tag   = tag_q;
    assign busy      = (state_q != IDLE);
`ifdef MEM_TIMEOUT_EN
    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
